branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage pipeline. Sits directly downstream of the instruction decoder's branch flag: when a decoded instruction is a branch in ID, it returns a taken/not-taken prediction from a table of 2-bit saturating counters. In EX it takes the resolved outcome, updates the table and raises a mispredict/flush signal. Optional gshare indexing is compiled in by macro.

## Interface
- IDX_W, 4: index width; the table has 2^IDX_W entries.
- GHR_W, 4: global history width; used only with gshare, must be <= IDX_W.
- CNT_W, 32: width of the statistics counters.

- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- predict_valid_i  input  1  ID holds a branch (the decoder's branch flag, gated by no-op/stall).
- predict_pc_i  input  32  PC of the ID instruction.
- predict_taken_o  output  1  prediction; combinational.
- predict_idx_o  output  IDX_W  table index used; carried down the pipeline to EX.
- update_valid_i  input  1  EX holds a resolved branch.
- update_idx_i  input  IDX_W  index carried from ID.
- update_pred_i  input  1  prediction carried from ID.
- update_taken_i  input  1  actual outcome.
- mispredict_o  output  1  update_valid_i & (update_pred_i != update_taken_i); combinational.
- branch_cnt_o  output  CNT_W  resolved-branch count.
- mispred_cnt_o  output  CNT_W  mispredict count.

## Operation
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken iff bit[1] = 1.
- Index, base: predict_pc_i[IDX_W+1:2].
- Predict path: predict_taken_o = table[predict_idx_o][1]. Outputs are driven regardless of predict_valid_i. The consumer qualifies them.
- Update, when update_valid_i = 1:
  - taken: counter += 1, saturating at 11.
  - not taken: counter -= 1, saturating at 00.
  - No wrap-around in either direction.
- Statistics: branch_cnt_o increments on every update_valid_i. mispred_cnt_o increments when mispredict_o = 1. Both saturate at all-ones.
- Same-cycle predict and update to the same index: the prediction reads the pre-update value. There is no bypass.
- update_valid_i = 0: no state changes. mispredict_o = 0.

## Timing
- Prediction: zero latency, combinational from the table and predict_pc_i.
- Update: the table write and statistics take effect at the rising edge ending the update cycle. They are visible to predictions from the next cycle.
- mispredict_o is valid in the same cycle as update_valid_i. The hazard unit uses it to flush IF/ID and redirect the PC.
- Reset values:
  - every table entry = 11 (ST).
  - GHR = 0.
  - branch_cnt_o = 0, mispred_cnt_o = 0.
  - predict_taken_o therefore reads 1 after reset.
- rst_i wins over a simultaneous update. An update presented during reset is discarded.
- Reset mid-stream restores the full table. There are no partial writes.

## Configuration
- BRANCH_PREDICTOR_GSHARE_EN defined:
  - A GHR_W-bit global history register is kept.
  - On each update it shifts left and takes update_taken_i into bit 0.
  - The index is the base index XOR {zero-extend GHR to IDX_W}.
  - The GHR updates at the same edge as the table.
- Not defined: no GHR register. The index is the base index only.

## Structure
- Package bp_pkg holds:
  - the 2-bit counter typedef and the SNT/WNT/WT/ST constants;
  - the reset state constant (ST);
  - the index computation function.
- One sub-module, sat_counter2: a 2-bit saturating up/down next-state function, instantiated in the update path.
- The table is a register array with per-entry synchronous reset, not RAM, because reset must clear every entry in one cycle.

## Test plan
- Reset, then predict_pc_i = 0x10 -> predict_idx_o = 4, predict_taken_o = 1; branch_cnt_o = 0, mispred_cnt_o = 0.
- Updates to idx 4 with pred=1, taken=0, twice, on consecutive cycles:
  - mispredict_o = 1 in both cycles;
  - entry goes 11 -> 10 -> 01; predict on 0x10 gives 0;
  - mispred_cnt_o = 2.
- Saturation:
  - three taken updates on an ST entry -> stays 11, prediction stays 1;
  - three not-taken updates from 01 -> 00 and stays there.
- Same-cycle predict 0x10 and not-taken update of idx 4 from 10:
  - predict_taken_o = 1 in that cycle, 0 the next cycle.
- rst_i asserted together with update_valid_i on an entry at 01:
  - entry reads 11 after reset; counters are 0; mispredict_o does not affect the counters.
- With BRANCH_PREDICTOR_GSHARE_EN defined:
  - one taken update gives GHR = 0001;
  - a predict on 0x10 then gives predict_idx_o = 5.
  - Without the macro the same sequence gives 4.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding, reset state
// and the table index function used by both the plain and gshare builds.
package bp_pkg;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t CNT_SNT   = 2'b00;
  localparam cnt2_t CNT_WNT   = 2'b01;
  localparam cnt2_t CNT_WT    = 2'b10;
  localparam cnt2_t CNT_ST    = 2'b11;
  localparam cnt2_t CNT_RESET = CNT_ST;

  // Word-aligned PC bits XORed with history; the caller truncates to its
  // index width, which discards the PC bits above the table.
  function automatic logic [31:0] bp_index(input logic [31:0] pc,
                                           input logic [31:0] hist);
    return (pc >> 2) ^ hist;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Predict (ID) and update (EX) signal bundle of the branch predictor.
// master = pipeline side, slave = predictor.
interface branch_predictor_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
);

  // Predict port: outputs are always driven; predict_valid_i only tells the
  // consumer whether to use them. Update port: one resolved branch per cycle
  // while update_valid_i is high, no backpressure.
  logic             predict_valid_i;
  logic [31:0]      predict_pc_i;
  logic             predict_taken_o;
  logic [IDX_W-1:0] predict_idx_o;

  logic             update_valid_i;
  logic [IDX_W-1:0] update_idx_i;
  logic             update_pred_i;
  logic             update_taken_i;
  logic             mispredict_o;

  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  modport master (
    output predict_valid_i, predict_pc_i,
    input  predict_taken_o, predict_idx_o,
    output update_valid_i, update_idx_i, update_pred_i, update_taken_i,
    input  mispredict_o, branch_cnt_o, mispred_cnt_o
  );

  modport slave (
    input  predict_valid_i, predict_pc_i,
    output predict_taken_o, predict_idx_o,
    input  update_valid_i, update_idx_i, update_pred_i, update_taken_i,
    output mispredict_o, branch_cnt_o, mispred_cnt_o
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function (no storage).
module sat_counter2
  import bp_pkg::*;
(
  input  cnt2_t cnt_i,
  input  logic  taken_i,
  output cnt2_t cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with 2-bit counters and resolved-branch statistics.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int GHR_W = 4,
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  branch_predictor_if.slave  bp
);

  localparam int TBL_N = 1 << IDX_W;

  cnt2_t            cnt_tbl_q [TBL_N];
  cnt2_t            cnt_tbl_d [TBL_N];
  cnt2_t            upd_cur;
  cnt2_t            upd_next;
  logic [31:0]      hist_ext;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
  logic             mispredict;
  logic             unused_predict_valid;

  // The predictor answers every cycle; qualification is the consumer's job.
  assign unused_predict_valid = bp.predict_valid_i;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign hist_ext = 32'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (bp.update_valid_i) ghr_d = GHR_W'({ghr_q, bp.update_taken_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign hist_ext = '0;
`endif

  // Predict path reads the registered table only, so a same-cycle update to
  // the same entry is not bypassed.
  assign bp.predict_idx_o   = IDX_W'(bp_index(bp.predict_pc_i, hist_ext));
  assign bp.predict_taken_o = cnt_tbl_q[bp.predict_idx_o][1];

  assign mispredict      = bp.update_valid_i & (bp.update_pred_i != bp.update_taken_i);
  assign bp.mispredict_o = mispredict;

  assign upd_cur = cnt_tbl_q[bp.update_idx_i];

  sat_counter2 u_sat_counter2 (
    .cnt_i   (upd_cur),
    .taken_i (bp.update_taken_i),
    .cnt_o   (upd_next)
  );

  always_comb begin
    for (int i = 0; i < TBL_N; i++) cnt_tbl_d[i] = cnt_tbl_q[i];
    if (bp.update_valid_i) cnt_tbl_d[bp.update_idx_i] = upd_next;
  end

  // Statistics saturate at all-ones rather than wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.update_valid_i && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (mispredict && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // Register array rather than RAM so reset restores every entry in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TBL_N; i++) cnt_tbl_q[i] <= CNT_RESET;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      for (int i = 0; i < TBL_N; i++) cnt_tbl_q[i] <= cnt_tbl_d[i];
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.branch_cnt_o  = branch_cnt_q;
  assign bp.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor; expectations are hand-derived
// per cycle and checked by an independent negedge monitor.
module tb_branch_predictor;

  logic clk_i;
  logic rst_i;

  branch_predictor_if #(.IDX_W(4), .CNT_W(32)) bp_if ();

  branch_predictor #(.IDX_W(4), .GHR_W(4), .CNT_W(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bp    (bp_if)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0]  idx;
    logic        taken;
    logic        mis;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic [3:0] ghr_m = 4'h0;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  localparam logic [3:0] GHR_PRED_IDX = 4'd5;
`else
  localparam logic [3:0] GHR_PRED_IDX = 4'd4;
`endif

  // PC that lands on table entry t given the history the bench expects.
  function automatic logic [31:0] pc_for(input logic [3:0] t);
    return {26'h0, t ^ ghr_m, 2'b00};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [31:0] pc,
                       input logic uv, input logic [3:0] uidx,
                       input logic upred, input logic utaken,
                       input logic [3:0] e_idx, input logic e_taken,
                       input logic e_mis, input int e_b, input int e_m,
                       input string nm);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i                 = rst;
    bp_if.predict_valid_i = 1'b1;
    bp_if.predict_pc_i    = pc;
    bp_if.update_valid_i  = uv;
    bp_if.update_idx_i    = uidx;
    bp_if.update_pred_i   = upred;
    bp_if.update_taken_i  = utaken;
    e.idx   = e_idx;
    e.taken = e_taken;
    e.mis   = e_mis;
    e.bcnt  = e_b;
    e.mcnt  = e_m;
    exp_q.push_back(e);
    name_q.push_back(nm);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    if (uv && !rst) ghr_m = {ghr_m[2:0], utaken};
`endif
    if (rst) ghr_m = 4'h0;
  endtask

  task automatic check(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t  mon_e;
  string mon_nm;
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      check(mon_nm, "idx",   32'(bp_if.predict_idx_o),   32'(mon_e.idx));
      check(mon_nm, "taken", 32'(bp_if.predict_taken_o), 32'(mon_e.taken));
      check(mon_nm, "mis",   32'(bp_if.mispredict_o),    32'(mon_e.mis));
      check(mon_nm, "bcnt",  bp_if.branch_cnt_o,         mon_e.bcnt);
      check(mon_nm, "mcnt",  bp_if.mispred_cnt_o,        mon_e.mcnt);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cyc;
    rst_i                 = 1'b1;
    bp_if.predict_valid_i = 1'b0;
    bp_if.predict_pc_i    = 32'h0;
    bp_if.update_valid_i  = 1'b0;
    bp_if.update_idx_i    = 4'h0;
    bp_if.update_pred_i   = 1'b0;
    bp_if.update_taken_i  = 1'b0;
    repeat (2) @(posedge clk_i);

    //    rst  pc                 uv  uidx  pr tk   idx    tk mis b   m
    drive(0, pc_for(4),          0, 4'd0, 0, 0,  4'd4,  1, 0,  0,  0, "reset_pred");
    drive(0, 32'hABCD_EF3C,      0, 4'd0, 0, 0,  4'hF,  1, 0,  0,  0, "pc_hi_ignored");
    drive(0, pc_for(4),          1, 4'd4, 1, 0,  4'd4,  1, 1,  0,  0, "mis1");
    drive(0, pc_for(4),          1, 4'd4, 1, 0,  4'd4,  1, 1,  1,  1, "mis2");
    drive(0, pc_for(4),          0, 4'd4, 1, 0,  4'd4,  0, 0,  2,  2, "after_two_nt");
    for (int k = 0; k < 3; k++)
      drive(0, pc_for(7),        1, 4'd7, 1, 1,  4'd7,  1, 0,  2 + k, 2, "sat_hi");
    drive(0, pc_for(7),          0, 4'd0, 0, 0,  4'd7,  1, 0,  5,  2, "sat_hi_hold");
    for (int k = 0; k < 3; k++)
      drive(0, pc_for(4),        1, 4'd4, 0, 0,  4'd4,  0, 0,  5 + k, 2, "sat_lo");
    drive(0, pc_for(4),          1, 4'd4, 0, 1,  4'd4,  0, 1,  8,  2, "lo_up1");
    drive(0, pc_for(4),          1, 4'd4, 0, 1,  4'd4,  0, 1,  9,  3, "lo_up2");
    drive(0, pc_for(4),          1, 4'd4, 1, 0,  4'd4,  1, 1, 10,  4, "same_cycle");
    drive(0, pc_for(4),          0, 4'd0, 0, 0,  4'd4,  0, 0, 11,  5, "same_cycle_next");
    drive(1, pc_for(4),          1, 4'd4, 1, 0,  4'd4,  0, 1, 11,  5, "rst_with_upd");
    drive(0, pc_for(4),          0, 4'd0, 0, 0,  4'd4,  1, 0,  0,  0, "post_rst");
    drive(0, 32'h10,             1, 4'd9, 1, 1,  4'd4,  1, 0,  0,  0, "ghr_upd");
    drive(0, 32'h10,             0, 4'd0, 0, 0,  GHR_PRED_IDX, 1, 0, 1, 0, "ghr_pred");

    @(posedge clk_i);
    #1;
    bp_if.update_valid_i  = 1'b0;
    bp_if.predict_valid_i = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk_i);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
